// File: rtl/custom_vec_scoreboard.sv
// Issue-side hazard scoreboard for the custom-vector coprocessor: tracks in-flight
// vector ops by id/vd and gates issue on RAW/WAW hazards, id reuse and capacity.
module custom_vec_scoreboard #(
    parameter int unsigned NrVregs     = 32,
    parameter int unsigned MaxInflight = 4,
    parameter int unsigned IdWidth     = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  logic [IdWidth-1:0]               issue_id_i,
    input  logic [$clog2(NrVregs)-1:0]       issue_vd_i,
    input  logic                             issue_vd_we_i,
    input  logic [$clog2(NrVregs)-1:0]       issue_vs1_i,
    input  logic [$clog2(NrVregs)-1:0]       issue_vs2_i,
    input  logic                             issue_vs1_re_i,
    input  logic                             issue_vs2_re_i,
    input  logic                             retire_valid_i,
    input  logic [IdWidth-1:0]               retire_id_i,
    input  logic                             flush_i,
    output logic [NrVregs-1:0]               busy_o,
    output logic [$clog2(MaxInflight+1)-1:0] inflight_cnt_o,
    output logic                             hazard_o,
    output logic                             retire_err_o
);
    localparam int unsigned VW = $clog2(NrVregs);
    localparam int unsigned CW = $clog2(MaxInflight + 1);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [VW-1:0]      vd;
        logic               we;
    } entry_t;

    logic   [MaxInflight-1:0] vld_q;
    entry_t [MaxInflight-1:0] ent_q;
    logic   [CW-1:0]          cnt_q;
    logic                     err_q;

    logic [MaxInflight-1:0] id_hit, ret_oh, alloc_oh;
    logic                   raw, waw, id_conflict, full, fire, ret_ok, found;

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < MaxInflight; i++)
            if (vld_q[i] && ent_q[i].we) busy_o[ent_q[i].vd] = 1'b1;
    end

    always_comb begin
        id_hit = '0;
        ret_oh = '0;
        for (int i = 0; i < MaxInflight; i++) begin
            id_hit[i] = vld_q[i] && (ent_q[i].id == issue_id_i);
            ret_oh[i] = retire_valid_i && vld_q[i] && (ent_q[i].id == retire_id_i);
        end
    end

    // Lowest-index free entry; only meaningful when not full.
    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < MaxInflight; i++)
            if (!vld_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
    end

    // Ready depends only on registered state and issue inputs, never on retire.
    assign raw         = (issue_vs1_re_i && busy_o[issue_vs1_i]) ||
                         (issue_vs2_re_i && busy_o[issue_vs2_i]);
    assign waw         = issue_vd_we_i && busy_o[issue_vd_i];
    assign id_conflict = |id_hit;
    assign full        = (cnt_q >= CW'(MaxInflight));
    assign ret_ok      = |ret_oh;

    assign issue_ready_o  = !raw && !waw && !id_conflict && !full && !flush_i;
    assign hazard_o       = issue_valid_i && (raw || waw || id_conflict);
    assign fire           = issue_valid_i && issue_ready_o;
    assign inflight_cnt_o = cnt_q;
    assign retire_err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            ent_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (flush_i) begin
            vld_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            // Alloc targets a free slot, retire a valid one, so they never collide.
            vld_q <= (vld_q & ~ret_oh) | (fire ? alloc_oh : '0);
            for (int i = 0; i < MaxInflight; i++)
                if (fire && alloc_oh[i])
                    ent_q[i] <= '{id: issue_id_i, vd: issue_vd_i, we: issue_vd_we_i};
            cnt_q <= cnt_q + CW'(fire) - CW'(ret_ok);
            err_q <= retire_valid_i && !ret_ok;
        end
    end

endmodule

// File: tb/tb_custom_vec_scoreboard.sv
// Directed bench for custom_vec_scoreboard: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_custom_vec_scoreboard;
    localparam int NV = 32;
    localparam int MI = 4;
    localparam int IW = 4;
    localparam int VW = $clog2(NV);
    localparam int CW = $clog2(MI + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          issue_valid_i = 1'b0, issue_ready_o;
    logic [IW-1:0] issue_id_i = '0;
    logic [VW-1:0] issue_vd_i = '0, issue_vs1_i = '0, issue_vs2_i = '0;
    logic          issue_vd_we_i = 1'b0, issue_vs1_re_i = 1'b0, issue_vs2_re_i = 1'b0;
    logic          retire_valid_i = 1'b0;
    logic [IW-1:0] retire_id_i = '0;
    logic          flush_i = 1'b0;
    logic [NV-1:0] busy_o;
    logic [CW-1:0] inflight_cnt_o;
    logic          hazard_o, retire_err_o;

    custom_vec_scoreboard #(.NrVregs(NV), .MaxInflight(MI), .IdWidth(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_vd_i(issue_vd_i), .issue_vd_we_i(issue_vd_we_i),
        .issue_vs1_i(issue_vs1_i), .issue_vs2_i(issue_vs2_i),
        .issue_vs1_re_i(issue_vs1_re_i), .issue_vs2_re_i(issue_vs2_re_i),
        .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i), .flush_i(flush_i),
        .busy_o(busy_o), .inflight_cnt_o(inflight_cnt_o),
        .hazard_o(hazard_o), .retire_err_o(retire_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Field masks: R=ready H=hazard B=busy C=count E=err; -1 means "don't check".
    typedef struct {
        string   name;
        int      rdy, haz, cnt, err;
        longint  busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string fld, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.rdy  >= 0) cmp(e.name, "ready",  longint'(issue_ready_o),  longint'(e.rdy));
            if (e.haz  >= 0) cmp(e.name, "hazard", longint'(hazard_o),       longint'(e.haz));
            if (e.cnt  >= 0) cmp(e.name, "count",  longint'(inflight_cnt_o), longint'(e.cnt));
            if (e.err  >= 0) cmp(e.name, "err",    longint'(retire_err_o),   longint'(e.err));
            if (e.busy >= 0) cmp(e.name, "busy",   longint'(busy_o),         e.busy);
        end
    end

    task automatic expect_out(input string nm, input int rdy, input int haz,
                              input int cnt, input int err, input longint busy);
        exp_t e;
        e.name = nm; e.rdy = rdy; e.haz = haz; e.cnt = cnt; e.err = err; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_vd_we_i = 0; issue_vs1_re_i = 0; issue_vs2_re_i = 0;
        retire_valid_i = 0; flush_i = 0;
    endtask

    task automatic issue(input int id, input int vd, input int we,
                         input int vs1, input int re1);
        issue_valid_i = 1; issue_id_i = IW'(id); issue_vd_i = VW'(vd);
        issue_vd_we_i = we[0]; issue_vs1_i = VW'(vs1); issue_vs1_re_i = re1[0];
        issue_vs2_i = '0; issue_vs2_re_i = 0;
    endtask

    task automatic retire(input int id);
        retire_valid_i = 1; retire_id_i = IW'(id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        expect_out("reset", 1, 0, 0, 0, 0);
        step(); rst_ni = 1;

        // Basic fire and busy update
        step(); idle(); issue(1, 3, 1, 0, 0); expect_out("t1_issue", 1, 0, 0, -1, 0);
        step(); idle(); expect_out("t1_after", -1, -1, 1, 0, 64'h8);

        // RAW block, retire does not unblock same cycle
        step(); issue(2, 10, 1, 3, 1); expect_out("raw_blk", 0, 1, 1, -1, 64'h8);
        step(); retire(1); expect_out("raw_ret_same", 0, 1, 1, -1, 64'h8);
        step(); retire_valid_i = 0; expect_out("raw_unblk", 1, 0, 0, 0, 0);
        step(); idle(); expect_out("raw_fired", -1, -1, 1, -1, 64'h400);
        step(); retire(2);
        step(); idle(); expect_out("raw_retired", -1, -1, 0, 0, 0);

        // Fill to capacity, same-cycle retire+issue
        for (int i = 0; i < 4; i++) begin
            step(); idle(); issue(i, 4 + i, 1, 0, 0);
            expect_out($sformatf("fill%0d", i), 1, 0, i, -1, -1);
        end
        step(); issue(8, 9, 1, 0, 0); expect_out("full", 0, 0, 4, -1, 64'hF0);
        step(); retire(2); expect_out("full_ret_same", 0, 0, 4, -1, 64'hF0);
        step(); retire_valid_i = 0; expect_out("full_after_ret", 1, 0, 3, 0, 64'hB0);
        step(); idle(); expect_out("full_refill", 0, 0, 4, -1, 64'h2B0);

        // Id conflict and bad retire
        step(); retire(0);
        step(); retire(1);
        step(); idle(); issue(5, 12, 1, 0, 0); expect_out("id5_first", 1, 0, 2, 0, 64'h280);
        step(); issue(5, 13, 1, 0, 0); expect_out("id_conflict", 0, 1, 3, -1, 64'h1280);
        step(); idle(); retire(12); expect_out("bad_ret_cyc", -1, -1, 3, 0, -1);
        step(); idle(); expect_out("bad_ret_pulse", -1, -1, 3, 1, 64'h1280);
        step(); expect_out("bad_ret_clear", -1, -1, 3, 0, -1);

        // Flush beats concurrent issue and retire
        step(); retire(3);
        step(); retire(8);
        step(); idle(); expect_out("pre_flush1", -1, -1, 1, 0, 64'h1000);
        step(); issue(6, 14, 1, 0, 0); expect_out("pre_flush_iss", 1, 0, 1, -1, -1);
        step(); idle(); issue(7, 15, 1, 0, 0); retire(5); flush_i = 1;
        expect_out("flush_cyc", 0, 0, 2, 0, 64'h5000);
        step(); idle(); expect_out("flush_after", 1, 0, 0, 0, 0);
        step(); expect_out("flush_noerr", 1, 0, 0, 0, 0);

        // Async reset with entries in flight
        for (int i = 1; i <= 3; i++) begin
            step(); idle(); issue(i, i, 1, 0, 0);
        end
        step(); idle(); expect_out("pre_rst", -1, -1, 3, 0, 64'hE);
        @(posedge clk_i); #3; rst_ni = 0; #1;
        expect_out("async_rst", 1, 0, 0, 0, 0);
        step(); rst_ni = 1;
        step(); issue(1, 3, 1, 0, 0); expect_out("post_rst_iss", 1, 0, 0, -1, 0);
        step(); idle(); expect_out("post_rst_fired", -1, -1, 1, 0, 64'h8);

        step();
        @(negedge clk_i); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/custom_vec_scoreboard.md
# custom_vec_scoreboard

Issue-side hazard scoreboard for the custom-vector CV-X-IF coprocessor. It tracks up to `MaxInflight` accepted vector operations by instruction id and destination vector register. It gates acceptance of new operations on RAW/WAW hazards, on free capacity and on id uniqueness. It sits between the instruction decoder and the issue handshake, and is released by retire events from the result-commit logic.

## Interface
Parameters:
- `NrVregs`, 32: number of architectural vector registers; register index width is `$clog2(NrVregs)`.
- `MaxInflight`, 4: in-flight table entries; must be ≥1.
- `IdWidth`, 4: CV-X-IF instruction id width.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous reset, active low
- `issue_valid_i`  in  1  decoded operation presented
- `issue_ready_o`  out  1  operation may be accepted this cycle
- `issue_id_i`  in  IdWidth  instruction id
- `issue_vd_i`  in  $clog2(NrVregs)  destination vreg
- `issue_vd_we_i`  in  1  operation writes `issue_vd_i`
- `issue_vs1_i`, `issue_vs2_i`  in  $clog2(NrVregs) each  source vregs
- `issue_vs1_re_i`, `issue_vs2_re_i`  in  1 each  source is read
- `retire_valid_i`  in  1  operation finished (result sent / VRF written)
- `retire_id_i`  in  IdWidth  id of finished operation
- `flush_i`  in  1  discard all in-flight state
- `busy_o`  out  NrVregs  bit i set = vreg i has a pending writer
- `inflight_cnt_o`  out  $clog2(MaxInflight+1)  occupied entries
- `hazard_o`  out  1  valid request blocked by RAW/WAW or id conflict
- `retire_err_o`  out  1  one-cycle pulse: retire id not in table

## Operation
- Table: `MaxInflight` entries {valid, id, vd, we}, held in flops. `busy_o` = OR over valid entries with `we` of onehot(vd).
- Hazard terms use only registered state:
  - RAW: `vs1_re` & busy[vs1], or `vs2_re` & busy[vs2].
  - WAW: `vd_we` & busy[vd].
  - Id conflict: any valid entry has id == `issue_id_i`.
- WAR is not tracked. Accepted operations read sources in issue order, before any later writer can be accepted.
- `issue_ready_o` = !RAW & !WAW & !idconflict & (count < MaxInflight). It is independent of `issue_valid_i`.
- `hazard_o` = `issue_valid_i` & (RAW | WAW | idconflict).
- Fire = `issue_valid_i` & `issue_ready_o`. On fire, the lowest-index free entry is written {1, id, vd, vd_we}. Operations with `vd_we`=0 (e.g. vector-to-scalar moves) still occupy an entry until retired.
- Retire: the entry whose valid id matches `retire_id_i` is cleared. Ids are unique, so at most one entry matches. No match → `retire_err_o` pulses next cycle and state is unchanged.
- Same-cycle fire and retire:
  - Both apply.
  - The freed entry is reusable only from the next cycle; retire never combinationally unblocks a same-cycle issue.
  - If the fire allocates the index being retired, no conflict arises: the retired entry was occupied, so it is not free.
  - Count: +1, −1, net 0.
- `flush_i` has priority over fire and retire. All entries are invalidated, count becomes 0, `retire_err_o` is not raised, and `issue_ready_o` is forced to 0 during the flush cycle.
- Count arithmetic: `inflight_cnt_o` is held as a counter. It must equal popcount(valid) at all times and never exceeds `MaxInflight` or underflows.

## Timing
- Reset (async assert, sync release): all entries invalid, `busy_o`=0, `inflight_cnt_o`=0, `retire_err_o`=0, `hazard_o`=0. `issue_ready_o`=1 while `flush_i`=0.
- `issue_ready_o` and `hazard_o` are combinational from registered state plus the `issue_*` inputs. There is no path from `retire_*` to ready.
- Fire at edge N → `busy_o`/count updated after edge N. A dependent op is blocked in cycle N+1.
- Retire at edge N → busy cleared after N. A dependent op can fire in cycle N+1.
- Reset mid-operation discards every in-flight entry; there is no partial state.

## Test plan
- Reset, then issue id=1 vd=3 we=1 → ready=1, fire. Next cycle `busy_o`=0x8, count=1.
- With vd=3 busy, issue vs1=3 re=1 → ready=0, hazard_o=1. Retire id=1 → next cycle ready=1, and the op fires.
- Fill 4 entries (ids 0–3, vd 4–7) → count=4, ready=0 for a hazard-free id=8. Retire id=2 and issue id=8 vd=9 in the same cycle → id 8 not accepted that cycle, accepted next cycle, count=4.
- Issue id=5 while id 5 in flight → ready=0, hazard_o=1. Retire id=12, not in flight → `retire_err_o`=1 for exactly one cycle, count unchanged.
- Two entries in flight, then `flush_i`=1 concurrently with a valid issue and a matching retire → ready=0 that cycle. Next cycle count=0, `busy_o`=0, no error pulse.
- Assert `rst_ni`=0 asynchronously with 3 entries in flight → outputs reach reset values before the next edge. Issue after release fires normally.
